// File: rtl/lsu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : lsu_pkg                                                      |
// | Description : Shared definitions for the load/store unit. Contains the    |
// |               funct3 access-size codes, the controller state type and a   |
// |               misalignment helper.                                        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package lsu_pkg;

    // funct3 access-size codes carried on DMCtrl
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } lsu_state_t;

    // True when the access cannot be served by a single naturally aligned lane.
    // Codes outside the defined set behave as word accesses.
    function automatic logic lsu_misaligned(input logic [2:0] ctrl, input logic [1:0] alo);
        case (ctrl)
            F3_B, F3_BU: lsu_misaligned = 1'b0;
            F3_H, F3_HU: lsu_misaligned = alo[0];
            default:     lsu_misaligned = (alo != 2'b00);
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : lsu_align                                                    |
// | Description : Combinational lane logic. Store side: byte enables and      |
// |               lane-replicated write data. Load side: lane extraction and   |
// |               sign/zero extension. Misaligned halves use A[1] only and     |
// |               misaligned words use lane 0 (truncating alignment).          |
// | Ports       : i_st_ctrl/i_st_alo/i_st_data -> o_be, o_wdata               |
// |               i_ld_ctrl/i_ld_alo/i_ld_rdata -> o_ld_data                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module lsu_align (
    input  logic [2:0]  i_st_ctrl,
    input  logic [1:0]  i_st_alo,
    input  logic [31:0] i_st_data,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    input  logic [2:0]  i_ld_ctrl,
    input  logic [1:0]  i_ld_alo,
    input  logic [31:0] i_ld_rdata,
    output logic [31:0] o_ld_data
);
    import lsu_pkg::*;

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Store lanes: the signed/unsigned distinction is meaningless for stores,
    // so BU/HU codes size like B/H; all remaining codes act as a word.
    always_comb begin
        o_be    = 4'b1111;
        o_wdata = i_st_data;
        case (i_st_ctrl)
            F3_B, F3_BU: begin
                o_be    = 4'b0001 << i_st_alo;
                o_wdata = {4{i_st_data[7:0]}};
            end
            F3_H, F3_HU: begin
                o_be    = 4'b0011 << {i_st_alo[1], 1'b0};
                o_wdata = {2{i_st_data[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        case (i_ld_alo)
            2'd0:    w_byte = i_ld_rdata[7:0];
            2'd1:    w_byte = i_ld_rdata[15:8];
            2'd2:    w_byte = i_ld_rdata[23:16];
            default: w_byte = i_ld_rdata[31:24];
        endcase
        w_half = i_ld_alo[1] ? i_ld_rdata[31:16] : i_ld_rdata[15:0];
    end

    always_comb begin
        case (i_ld_ctrl)
            F3_B:    o_ld_data = {{24{w_byte[7]}}, w_byte};
            F3_BU:   o_ld_data = {24'd0, w_byte};
            F3_H:    o_ld_data = {{16{w_half[15]}}, w_half};
            F3_HU:   o_ld_data = {16'd0, w_half};
            default: o_ld_data = i_ld_rdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lsu_mem_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : lsu_mem_ctrl                                                 |
// | Description : Load/store unit bridging core data-memory controls to a     |
// |               valid/grant memory bus. Stalls the core for each access,    |
// |               returns extended load data on DataRd with a Done pulse and   |
// |               reports timeouts with BusErr.                               |
// | Parameters  : TIMEOUT  - REQ/WAIT cycle limit before BusErr (0 = off)      |
// |               RST_DATA - reset/timeout value of DataRd                     |
// | Ports       : clk, rst_n (async, active low)                               |
// |               core : DMRd, DMWr, DMCtrl, Address, DataStore ->             |
// |                      DataRd, Stall, Done, BusErr                           |
// |               bus  : mem_req, mem_we, mem_addr, mem_be, mem_wdata ->       |
// |                      mem_gnt, mem_rvalid, mem_rdata                        |
// | Options     : LSU_MISALIGN_TRAP_EN - misaligned H/HU/W accesses are not    |
// |               issued; they complete at once with BusErr.                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module lsu_mem_ctrl #(
    parameter logic [7:0]  TIMEOUT  = 8'd255,
    parameter logic [31:0] RST_DATA = 32'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        DMRd,
    input  logic        DMWr,
    input  logic [2:0]  DMCtrl,
    input  logic [31:0] Address,
    input  logic [31:0] DataStore,
    output logic [31:0] DataRd,
    output logic        Stall,
    output logic        Done,
    output logic        BusErr,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);
    import lsu_pkg::*;

    lsu_state_t  r_state;
    lsu_state_t  w_next;
    logic [7:0]  r_cnt;
    logic [2:0]  r_ctrl;
    logic [1:0]  r_alo;
    logic        r_err;

    logic        w_req;
    logic        w_store;
    logic        w_tmo;
    logic        w_issue;
    logic        w_capture;
    logic        w_tmo_err;
    logic        w_trap;
    logic        w_misal_trap;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_ld_data;

    // A simultaneous load and store request is served as a load.
    assign w_req   = DMRd | DMWr;
    assign w_store = DMWr & ~DMRd;

    // r_cnt holds the number of REQ/WAIT cycles already completed, so the
    // limit is reached in the TIMEOUT-th cycle.
    assign w_tmo = (TIMEOUT != 8'd0) && (r_cnt == (TIMEOUT - 8'd1));

`ifdef LSU_MISALIGN_TRAP_EN
    assign w_misal_trap = lsu_misaligned(DMCtrl, Address[1:0]);
`else
    assign w_misal_trap = 1'b0;
`endif

    // Store lanes come from the live inputs (registered at issue); load
    // extraction uses the size/lane latched at issue.
    lsu_align u_align (
        .i_st_ctrl  (DMCtrl),
        .i_st_alo   (Address[1:0]),
        .i_st_data  (DataStore),
        .o_be       (w_be),
        .o_wdata    (w_wdata),
        .i_ld_ctrl  (r_ctrl),
        .i_ld_alo   (r_alo),
        .i_ld_rdata (mem_rdata),
        .o_ld_data  (w_ld_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // A completing handshake wins over a timeout in the same cycle.
    always_comb begin
        w_next    = r_state;
        Stall     = 1'b0;
        w_issue   = 1'b0;
        w_capture = 1'b0;
        w_tmo_err = 1'b0;
        w_trap    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    Stall = 1'b1;
                    if (w_misal_trap) begin
                        w_trap = 1'b1;
                        w_next = RESP;
                    end else begin
                        w_issue = 1'b1;
                        w_next  = REQ;
                    end
                end
            end
            REQ: begin
                Stall = 1'b1;
                if (mem_gnt && (mem_we || mem_rvalid)) begin
                    w_capture = ~mem_we;
                    w_next    = RESP;
                end else if (w_tmo) begin
                    w_tmo_err = 1'b1;
                    w_next    = RESP;
                end else if (mem_gnt) begin
                    w_next = WAIT;
                end
            end
            WAIT: begin
                Stall = 1'b1;
                if (mem_rvalid) begin
                    w_capture = 1'b1;
                    w_next    = RESP;
                end else if (w_tmo) begin
                    w_tmo_err = 1'b1;
                    w_next    = RESP;
                end
            end
            RESP: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    assign mem_req = (r_state == REQ);
    assign Done    = (r_state == RESP);
    assign BusErr  = r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_be    <= 4'd0;
            mem_wdata <= 32'd0;
            r_ctrl    <= F3_W;
            r_alo     <= 2'd0;
            r_cnt     <= 8'd0;
            r_err     <= 1'b0;
            DataRd    <= RST_DATA;
        end else begin
            r_err <= w_trap | w_tmo_err;
            if (w_issue) begin
                mem_we    <= w_store;
                mem_addr  <= {Address[31:2], 2'b00};
                mem_be    <= w_be;
                mem_wdata <= w_wdata;
                r_ctrl    <= DMCtrl;
                r_alo     <= Address[1:0];
                r_cnt     <= 8'd0;
            end else if ((r_state == REQ) || (r_state == WAIT)) begin
                r_cnt <= r_cnt + 8'd1;
            end
            if (w_capture)      DataRd <= w_ld_data;
            else if (w_tmo_err) DataRd <= RST_DATA;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_lsu_mem_ctrl                                              |
// | Description : Self-checking bench for lsu_mem_ctrl. Directed vector table, |
// |               randomized transactions against a behavioural model, and    |
// |               hand-written reset-in-flight and timeout sequences.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_lsu_mem_ctrl;

    localparam logic [31:0] RST   = 32'h0BAD_F00D;
    localparam int          TMO   = 255;
    localparam int          BOUND = 300;

    logic        clk;
    logic        rst_n;
    logic        DMRd, DMWr;
    logic [2:0]  DMCtrl;
    logic [31:0] Address, DataStore;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;

    logic [31:0] DataRd, mem_addr, mem_wdata;
    logic        Stall, Done, BusErr, mem_req, mem_we;
    logic [3:0]  mem_be;

    logic [31:0] t4_DataRd, t4_mem_addr, t4_mem_wdata;
    logic        t4_Stall, t4_Done, t4_BusErr, t4_mem_req, t4_mem_we;
    logic [3:0]  t4_mem_be;

    lsu_mem_ctrl #(.TIMEOUT(8'd255), .RST_DATA(RST)) u_dut (
        .clk(clk), .rst_n(rst_n), .DMRd(DMRd), .DMWr(DMWr), .DMCtrl(DMCtrl),
        .Address(Address), .DataStore(DataStore), .DataRd(DataRd), .Stall(Stall),
        .Done(Done), .BusErr(BusErr), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    lsu_mem_ctrl #(.TIMEOUT(8'd4), .RST_DATA(RST)) u_dut_t4 (
        .clk(clk), .rst_n(rst_n), .DMRd(DMRd), .DMWr(DMWr), .DMCtrl(DMCtrl),
        .Address(Address), .DataStore(DataStore), .DataRd(t4_DataRd), .Stall(t4_Stall),
        .Done(t4_Done), .BusErr(t4_BusErr), .mem_req(t4_mem_req), .mem_we(t4_mem_we),
        .mem_addr(t4_mem_addr), .mem_be(t4_mem_be), .mem_wdata(t4_mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  ctrl;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] rdata;
        int          g;       // REQ cycles without grant before the grant cycle
        int          r;       // cycles from grant to rvalid (0 = same cycle)
        logic [31:0] e_addr;
        logic        e_we;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic        keep;    // DataRd expected to keep its previous value
        logic [31:0] e_data;
        logic        e_err;
        int          e_done;  // cycle of Done, request cycle = 1
    } vec_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] m_data;      // model of the DataRd register

    function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endfunction

    function automatic vec_t mk(input logic rd, input logic wr, input logic [2:0] ctrl,
                                input logic [31:0] addr, input logic [31:0] sdata,
                                input logic [31:0] rdata, input int g, input int r,
                                input logic [31:0] e_addr, input logic e_we, input logic [3:0] e_be,
                                input logic [31:0] e_wdata, input logic keep,
                                input logic [31:0] e_data, input logic e_err, input int e_done);
        vec_t v;
        v.rd = rd; v.wr = wr; v.ctrl = ctrl; v.addr = addr; v.sdata = sdata; v.rdata = rdata;
        v.g = g; v.r = r; v.e_addr = e_addr; v.e_we = e_we; v.e_be = e_be; v.e_wdata = e_wdata;
        v.keep = keep; v.e_data = e_data; v.e_err = e_err; v.e_done = e_done;
        return v;
    endfunction

    // Reference model: access size from funct3, lane from the address with
    // truncation to the size, extension by arithmetic on the shifted word.
    function automatic vec_t model(input vec_t t);
        vec_t        v;
        int          sz, lane, cnt;
        logic [31:0] x;
        v = t;
        if (t.ctrl == 3'd0 || t.ctrl == 3'd4)      sz = 1;
        else if (t.ctrl == 3'd1 || t.ctrl == 3'd5) sz = 2;
        else                                       sz = 4;
        lane = int'(t.addr[1:0]);
        lane = lane - (lane % sz);
        v.e_addr = t.addr & ~32'h3;
        v.e_we   = !t.rd;
        v.e_be   = 4'(((1 << sz) - 1) << lane);
        if (sz == 1)      v.e_wdata = (t.sdata & 32'hFF) * 32'h0101_0101;
        else if (sz == 2) v.e_wdata = (t.sdata & 32'hFFFF) * 32'h0001_0001;
        else              v.e_wdata = t.sdata;
        x = t.rdata >> (8 * lane);
        if (sz == 1) begin
            x = x & 32'hFF;
            if (t.ctrl == 3'd0 && x >= 32'h80) x = x - 32'h100;
        end else if (sz == 2) begin
            x = x & 32'hFFFF;
            if (t.ctrl == 3'd1 && x >= 32'h8000) x = x - 32'h1_0000;
        end
        cnt = t.rd ? (t.g + 1 + t.r) : (t.g + 1);
        v.e_err  = (cnt > TMO);
        v.e_done = (v.e_err ? TMO : cnt) + 2;
        v.keep   = !t.rd;
        v.e_data = v.e_err ? RST : x;
`ifdef LSU_MISALIGN_TRAP_EN
        if (sz > 1 && (int'(t.addr[1:0]) % sz) != 0) begin
            v.e_err = 1'b1; v.e_done = 2; v.keep = 1'b1;
        end
`endif
        return v;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        DMRd = 1'b0; DMWr = 1'b0; DMCtrl = 3'd0; Address = 32'd0; DataStore = 32'd0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        m_data = RST;
    endtask

    // Plays one access on the main DUT, acting as the memory.
    task automatic run_txn(input vec_t v, input string tag);
        logic [31:0] exp_d;
        bit          stall_bad, req_bad, seen;
        int          c;
        exp_d = v.keep ? m_data : v.e_data;
        stall_bad = 1'b0; req_bad = 1'b0; seen = 1'b0;
        DMRd = v.rd; DMWr = v.wr; DMCtrl = v.ctrl; Address = v.addr; DataStore = v.sdata;
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        #1;
        if (!Stall)  stall_bad = 1'b1;
        if (mem_req) req_bad   = 1'b1;
        @(posedge clk); #1;
        for (c = 1; c <= BOUND; c++) begin
            if (Done) begin seen = 1'b1; break; end
            mem_gnt    = (c == v.g + 1);
            mem_rvalid = v.rd && (c == v.g + 1 + v.r);
            mem_rdata  = mem_rvalid ? v.rdata : $urandom();
            #1;
            if (!Stall) stall_bad = 1'b1;
            if (mem_req != (c <= v.g + 1)) req_bad = 1'b1;
            if (c == 1) begin
                chk({tag, " mem_addr"}, mem_addr, v.e_addr);
                chk({tag, " mem_we"}, 32'(mem_we), 32'(v.e_we));
                if (v.wr && !v.rd) begin
                    chk({tag, " mem_be"}, 32'(mem_be), 32'(v.e_be));
                    chk({tag, " mem_wdata"}, mem_wdata, v.e_wdata);
                end
            end
            @(posedge clk); #1;
        end
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        chk({tag, " done cycle"}, seen ? 32'(c + 1) : 32'hFFFF_FFFF, 32'(v.e_done));
        if (!seen) begin
            do_reset();
            return;
        end
        chk({tag, " stall during access"}, 32'(stall_bad), 32'd0);
        chk({tag, " mem_req shape"}, 32'(req_bad), 32'd0);
        chk({tag, " BusErr"}, 32'(BusErr), 32'(v.e_err));
        chk({tag, " DataRd"}, DataRd, exp_d);
        chk({tag, " Stall at Done"}, 32'(Stall), 32'd0);
        chk({tag, " mem_req at Done"}, 32'(mem_req), 32'd0);
        m_data = exp_d;
        DMRd = 1'b0; DMWr = 1'b0;
        @(posedge clk); #1;
        mem_rvalid = 1'b1; mem_rdata = $urandom();
        #1;
        chk({tag, " Done pulse"}, 32'({Done, BusErr, Stall}), 32'd0);
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        chk({tag, " DataRd hold"}, DataRd, exp_d);
    endtask

    vec_t tbl[12];

    initial begin
        vec_t v;
        bit   bad;
        int   k;

        // rd wr ctrl  addr        sdata         rdata         g r  e_addr       we be       e_wdata       keep e_data        err done
        tbl[0]  = mk(1, 0, 3'd0, 32'h103, 32'h0,        32'h80FF_FF7F, 0, 0, 32'h100, 0, 4'b0000, 32'h0,        0, 32'hFFFF_FF80, 0, 3);
        tbl[1]  = mk(1, 0, 3'd5, 32'h102, 32'h0,        32'h8001_0000, 1, 2, 32'h100, 0, 4'b0000, 32'h0,        0, 32'h0000_8001, 0, 6);
        tbl[2]  = mk(0, 1, 3'd0, 32'h41,  32'h1234_56AB, 32'h0,        0, 0, 32'h40,  1, 4'b0010, 32'hABAB_ABAB, 1, 32'h0,        0, 3);
        tbl[3]  = mk(0, 1, 3'd1, 32'h42,  32'hCAFE_1234, 32'h0,        2, 0, 32'h40,  1, 4'b1100, 32'h1234_1234, 1, 32'h0,        0, 5);
        tbl[4]  = mk(0, 1, 3'd2, 32'h80,  32'hDEAD_BEEF, 32'h0,        0, 0, 32'h80,  1, 4'b1111, 32'hDEAD_BEEF, 1, 32'h0,        0, 3);
        tbl[5]  = mk(1, 0, 3'd1, 32'h100, 32'h0,        32'h1234_F00F, 0, 1, 32'h100, 0, 4'b0000, 32'h0,        0, 32'hFFFF_F00F, 0, 4);
        tbl[6]  = mk(1, 0, 3'd4, 32'h101, 32'h0,        32'h1234_F0AB, 0, 0, 32'h100, 0, 4'b0000, 32'h0,        0, 32'h0000_00F0, 0, 3);
        tbl[7]  = mk(1, 0, 3'd2, 32'h200, 32'h0,        32'h89AB_CDEF, 0, 3, 32'h200, 0, 4'b0000, 32'h0,        0, 32'h89AB_CDEF, 0, 6);
        tbl[8]  = mk(1, 0, 3'd2, 32'h2,   32'h0,        32'h1122_3344, 0, 0, 32'h0,   0, 4'b0000, 32'h0,        0, 32'h1122_3344, 0, 3);
        tbl[9]  = mk(1, 0, 3'd1, 32'h103, 32'h0,        32'h7FFE_0001, 0, 0, 32'h100, 0, 4'b0000, 32'h0,        0, 32'h0000_7FFE, 0, 3);
        tbl[10] = mk(1, 0, 3'd3, 32'h104, 32'h0,        32'hCAFE_BABE, 0, 0, 32'h104, 0, 4'b0000, 32'h0,        0, 32'hCAFE_BABE, 0, 3);
        tbl[11] = mk(1, 1, 3'd0, 32'h100, 32'h0,        32'h0000_00FF, 0, 0, 32'h100, 0, 4'b0000, 32'h0,        0, 32'hFFFF_FFFF, 0, 3);
`ifdef LSU_MISALIGN_TRAP_EN
        tbl[8].e_err = 1'b1; tbl[8].e_done = 2; tbl[8].keep = 1'b1;
        tbl[9].e_err = 1'b1; tbl[9].e_done = 2; tbl[9].keep = 1'b1;
`endif

        do_reset();
        #1;
        chk("reset mem_req",   32'(mem_req), 32'd0);
        chk("reset mem_we",    32'(mem_we), 32'd0);
        chk("reset mem_be",    32'(mem_be), 32'd0);
        chk("reset mem_addr",  mem_addr, 32'd0);
        chk("reset mem_wdata", mem_wdata, 32'd0);
        chk("reset Done",      32'(Done), 32'd0);
        chk("reset BusErr",    32'(BusErr), 32'd0);
        chk("reset Stall",     32'(Stall), 32'd0);
        chk("reset DataRd",    DataRd, RST);
        chk("reset t4 DataRd", t4_DataRd, RST);
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 150; i++) begin
            k = int'($urandom_range(0, 3));
            v.rd    = (k != 0);
            v.wr    = (k == 0) || (k == 3);
            v.ctrl  = 3'($urandom_range(0, 7));
            v.addr  = $urandom();
            v.sdata = $urandom();
            v.rdata = $urandom();
            v.g     = int'($urandom_range(0, 3));
            v.r     = int'($urandom_range(0, 3));
            run_txn(model(v), $sformatf("rnd%0d", i));
        end

        // Reset while waiting for read data: everything returns to reset
        // values immediately and the orphaned rvalid is ignored.
        do_reset();
        @(posedge clk); #1;
        run_txn(model(mk(1, 0, 3'd2, 32'h300, 32'h0, 32'h1357_9BDF, 0, 0,
                         32'h0, 0, 4'h0, 32'h0, 0, 32'h0, 0, 0)), "preload");
        DMRd = 1'b1; DMCtrl = 3'd2; Address = 32'h400;
        @(posedge clk); #1;
        mem_gnt = 1'b1;
        @(posedge clk); #1;
        mem_gnt = 1'b0;
        #1;
        chk("wait mem_req", 32'({mem_req, Stall}), 32'b01);
        rst_n = 1'b0; DMRd = 1'b0;
        #1;
        chk("midrst DataRd",   DataRd, RST);
        chk("midrst mem_addr", mem_addr, 32'd0);
        chk("midrst outputs",  32'({Done, BusErr, Stall, mem_req}), 32'd0);
        mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_0000;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("postrst DataRd",  DataRd, RST);
        chk("postrst outputs", 32'({Done, BusErr, Stall, mem_req}), 32'd0);
        mem_rvalid = 1'b0;

        // Timeout on the TIMEOUT=4 instance: grant never arrives.
        do_reset();
        @(posedge clk); #1;
        run_txn(model(mk(1, 0, 3'd2, 32'h300, 32'h0, 32'h5555_AAAA, 0, 0,
                         32'h0, 0, 4'h0, 32'h0, 0, 32'h0, 0, 0)), "t4 preload");
        chk("t4 preload DataRd", t4_DataRd, 32'h5555_AAAA);
        DMRd = 1'b1; DMCtrl = 3'd2; Address = 32'h304;
        @(posedge clk); #1;
        bad = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            if (!t4_mem_req || t4_Done || !t4_Stall) bad = 1'b1;
            @(posedge clk); #1;
        end
        chk("t4 REQ window",  32'(bad), 32'd0);
        chk("t4 Done",        32'(t4_Done), 32'd1);
        chk("t4 BusErr",      32'(t4_BusErr), 32'd1);
        chk("t4 DataRd",      t4_DataRd, RST);
        chk("t4 mem_req off", 32'(t4_mem_req), 32'd0);
        DMRd = 1'b0;
        @(posedge clk); #1;
        chk("t4 pulse end",   32'({t4_Done, t4_BusErr}), 32'd0);
        do_reset();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
